// File: rtl/cond_pkg.sv
// cond_pkg
// Shared definitions for the execute-stage condition unit.
//   cond_e       : the 16 condition-field codes
//   FLAG_N..V    : bit positions of each flag inside an {N,Z,C,V} vector
//   FW_NZ, FW_CV : bit positions inside the 2-bit FlagWrite field
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagWrite[FW_NZ] guards flags[3:2], FlagWrite[FW_CV] guards flags[1:0].
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check
// Purely combinational condition evaluator.
//   cond   [3:0] in  : instruction condition field
//   flags  [3:0] in  : committed flags, {N,Z,C,V}
//   condex       out : 1 when the instruction is allowed to execute
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condex = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      COND_NV: condex = 1'b0;  // reserved encoding never executes
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_stage.sv
// cond_flag_stage
// Execute-stage condition unit: holds the NZCV flag register, evaluates the
// condition field against it, qualifies the decoder enables and registers
// them into the Memory stage.
//   clk, reset (sync, active-high)
//   ALUFlags[3:0]  : {N,Z,C,V} produced for the Execute instruction
//   CondE[3:0]     : condition field
//   FlagWriteE[1:0]: [1] N,Z update enable, [0] C,V update enable
//   PCSE, RegWE, MemWE, BranchE : unqualified enables
//   StallE, FlushE : hold / squash the Execute instruction
//   CondExE        : combinational condition result
//   FlagsQ[3:0]    : committed flags
//   PCSrcM, RegWriteM, MemWriteM, CondExM : registered qualified outputs
module cond_flag_stage
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ALUFlags,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic       PCSE,
  input  logic       RegWE,
  input  logic       MemWE,
  input  logic       BranchE,
  input  logic       StallE,
  input  logic       FlushE,
  output logic       CondExE,
  output logic [3:0] FlagsQ,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       CondExM
);

  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic       commit;
  logic       pcsrc_next, regwrite_next, memwrite_next;
  logic       pcsrc_reg, regwrite_reg, memwrite_reg, condex_reg;

  // Evaluation always uses the committed flags, so a dependent instruction
  // following a flag setter sees the new value the cycle after commit.
  cond_check u_cond_check (
    .cond   (CondE),
    .flags  (flags_reg),
    .condex (CondExE)
  );

  // A squashed or stalled instruction must not disturb the flags.
  assign commit = CondExE & ~StallE & ~FlushE;

  // Each FlagWrite bit owns one 2-bit half of the flag vector.
  for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
    assign flags_next[2*gi+1 -: 2] = (commit && FlagWriteE[gi])
                                     ? ALUFlags[2*gi+1 -: 2]
                                     : flags_reg[2*gi+1 -: 2];
  end

  assign pcsrc_next    = (PCSE | BranchE) & CondExE;
  assign regwrite_next = RegWE & CondExE;
  assign memwrite_next = MemWE & CondExE;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= RESET_FLAGS;
    end else begin
      flags_reg <= flags_next;
    end
  end

  // Priority: reset, then flush (wins over a concurrent stall), then stall.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      pcsrc_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memwrite_reg <= 1'b0;
      condex_reg   <= 1'b0;
    end else if (!StallE) begin
      pcsrc_reg    <= pcsrc_next;
      regwrite_reg <= regwrite_next;
      memwrite_reg <= memwrite_next;
      condex_reg   <= CondExE;
    end
  end

  assign FlagsQ    = flags_reg;
  assign PCSrcM    = pcsrc_reg;
  assign RegWriteM = regwrite_reg;
  assign MemWriteM = memwrite_reg;
  assign CondExM   = condex_reg;

endmodule

// File: tb/tb_cond_flag_stage.sv
// tb_cond_flag_stage
// Scoreboard bench: a driver issues one instruction per cycle, predicts the
// response with an abstract model and queues the expectations tagged with the
// cycle in which they must appear; a monitor on the falling edge pops and
// compares them. Directed cases come first, then randomized traffic.
module tb_cond_flag_stage;

  localparam logic [3:0] RF = 4'b0100;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ALUFlags, CondE;
  logic [1:0] FlagWriteE;
  logic       PCSE, RegWE, MemWE, BranchE, StallE, FlushE;
  logic       CondExE, PCSrcM, RegWriteM, MemWriteM, CondExM;
  logic [3:0] FlagsQ;

  cond_flag_stage #(.RESET_FLAGS(RF)) dut (
    .clk(clk), .reset(reset), .ALUFlags(ALUFlags), .CondE(CondE),
    .FlagWriteE(FlagWriteE), .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE),
    .BranchE(BranchE), .StallE(StallE), .FlushE(FlushE),
    .CondExE(CondExE), .FlagsQ(FlagsQ), .PCSrcM(PCSrcM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .CondExM(CondExM)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       cx;
  } cx_t;

  typedef struct {
    int         due;
    logic [3:0] flags;
    logic       pcs, regw, memw, cxm;
  } st_t;

  cx_t cx_q[$];
  st_t st_q[$];

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  bit run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Abstract reference: conditions come in complementary pairs; the upper
  // three bits pick a base predicate and the low bit inverts it.
  logic [3:0] m_flags;
  logic       m_pcs, m_regw, m_memw, m_cxm;

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c >> 1)
      0: base = z;
      1: base = cc;
      2: base = n;
      3: base = v;
      4: base = cc && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    else
      passed++;
  endtask

  // Monitor: compares everything due in the current cycle.
  always @(negedge clk) begin : monitor
    cx_t ce;
    st_t se;
    if (run) begin
      while (cx_q.size() > 0 && cx_q[0].due == cyc) begin
        ce = cx_q.pop_front();
        chk("CondExE", {3'b0, CondExE}, {3'b0, ce.cx});
      end
      while (st_q.size() > 0 && st_q[0].due == cyc) begin
        se = st_q.pop_front();
        chk("FlagsQ", FlagsQ, se.flags);
        chk("PCSrcM", {3'b0, PCSrcM}, {3'b0, se.pcs});
        chk("RegWriteM", {3'b0, RegWriteM}, {3'b0, se.regw});
        chk("MemWriteM", {3'b0, MemWriteM}, {3'b0, se.memw});
        chk("CondExM", {3'b0, CondExM}, {3'b0, se.cxm});
        $display("cyc=%0d flags=%b pcs=%b rw=%b mw=%b cxm=%b cxe=%b",
                 cyc, FlagsQ, PCSrcM, RegWriteM, MemWriteM, CondExM, CondExE);
      end
    end
  end

  // Drive one instruction for one cycle and queue its expected effects.
  task automatic step(input logic rst, input logic [3:0] alu, input logic [3:0] cond,
                      input logic [1:0] fw, input logic pcs, input logic rw,
                      input logic mw, input logic br, input logic st, input logic fl);
    logic cx;
    cx_t  ce;
    st_t  se;
    @(posedge clk);
    #1;
    reset = rst; ALUFlags = alu; CondE = cond; FlagWriteE = fw;
    PCSE = pcs; RegWE = rw; MemWE = mw; BranchE = br; StallE = st; FlushE = fl;

    cx = ref_cond(cond, m_flags);
    ce.due = cyc; ce.cx = cx;
    cx_q.push_back(ce);

    if (rst) begin
      m_flags = RF;
      {m_pcs, m_regw, m_memw, m_cxm} = 4'b0;
    end else begin
      if (cx && !st && !fl) begin
        if (fw[1]) m_flags[3:2] = alu[3:2];
        if (fw[0]) m_flags[1:0] = alu[1:0];
      end
      if (fl) begin
        {m_pcs, m_regw, m_memw, m_cxm} = 4'b0;
      end else if (!st) begin
        m_pcs  = (pcs || br) && cx;
        m_regw = rw && cx;
        m_memw = mw && cx;
        m_cxm  = cx;
      end
    end
    se.due = cyc + 1; se.flags = m_flags;
    se.pcs = m_pcs; se.regw = m_regw; se.memw = m_memw; se.cxm = m_cxm;
    st_q.push_back(se);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b1; ALUFlags = '0; CondE = '0; FlagWriteE = '0;
    PCSE = 0; RegWE = 0; MemWE = 0; BranchE = 0; StallE = 0; FlushE = 0;
    repeat (2) @(posedge clk);
    m_flags = RF;
    {m_pcs, m_regw, m_memw, m_cxm} = 4'b0;
    run = 1'b1;

    //   rst  alu      cond     fw     pcs rw mw br st fl
    step(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0); // EQ on reset flags (Z=1)
    step(0, 4'b1001, 4'b1110, 2'b11, 0, 0, 0, 0, 0, 0); // AL full write -> 1001
    step(0, 4'b0000, 4'b1011, 2'b00, 0, 0, 0, 0, 0, 0); // LT -> 0
    step(0, 4'b0000, 4'b1010, 2'b00, 0, 0, 0, 0, 0, 0); // GE -> 1
    step(0, 4'b0111, 4'b1110, 2'b10, 0, 0, 0, 0, 0, 0); // N,Z only -> 0101
    step(0, 4'b0000, 4'b0001, 2'b11, 1, 1, 1, 0, 0, 0); // NE with Z=1, suppressed
    step(0, 4'b0000, 4'b1110, 2'b00, 0, 1, 0, 0, 0, 0); // RegWriteM -> 1
    step(0, 4'b0000, 4'b1110, 2'b11, 1, 1, 1, 0, 1, 0); // stall: hold all
    step(0, 4'b0000, 4'b1110, 2'b11, 1, 1, 1, 0, 1, 1); // stall+flush: clear
    step(0, 4'b0000, 4'b1110, 2'b00, 1, 1, 1, 1, 0, 0); // outputs set again
    step(1, 4'b1111, 4'b1110, 2'b11, 1, 1, 1, 0, 0, 1); // reset beats write/flush
    step(0, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 0); // EQ true, flags -> 0000
    step(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0); // EQ false with Z=0
    for (int i = 0; i < 16; i++) begin
      step(0, 4'(i), 4'b1110, 2'b11, 0, 0, 0, 0, 0, 0);
      step(0, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 1, 0, 0); // NV never executes
    end

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0),
           4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (cx_q.size() != 0 || st_q.size() != 0)
      $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", cx_q.size(), st_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
